// File: rtl/fp_std_0.sv
// Front stage of the 24-bit FP add/max/min unit: magnitude ordering, alignment, raw sum/diff.
// Optional inexact flag output enabled by defining FP_STD_0_INEXACT_EN.
module fp_std_0 #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [3:0]       op_o,
  output logic [16:0]      add_result_mantissa_o,
  output logic [15:0]      sub_result_mantissa_o,
  output logic             max_sign_o,
  output logic             min_sign_o,
  output logic [WIDTH-1:0] max_result_o,
  output logic [WIDTH-1:0] min_result_o,
  output logic [7:0]       max_exponent_o
`ifdef FP_STD_0_INEXACT_EN
  ,
  output logic             inexact_o
`endif
);

  localparam int EW = 8;
  localparam int MW = 15;
  localparam int SW = MW + 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             swap;
    logic [EW-1:0]    exp_diff;
    logic [WIDTH-1:0] max_res;
    logic [WIDTH-1:0] min_res;
  } stg_a_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [SW:0]      add;
    logic [SW-1:0]    sub;
    logic             max_sign;
    logic             min_sign;
    logic [WIDTH-1:0] max_res;
    logic [WIDTH-1:0] min_res;
    logic [EW-1:0]    max_exp;
`ifdef FP_STD_0_INEXACT_EN
    logic             inexact;
`endif
  } stg_b_t;

  // Zero exponent encodes zero regardless of mantissa bits.
  function automatic logic [SW-1:0] sig_of(input logic [WIDTH-1:0] x);
    return (x[WIDTH-2 -: EW] == '0) ? '0 : {1'b1, x[MW-1:0]};
  endfunction

  logic [1:0] vld_pipe;  // [0] stage A, [1] stage B
  stg_a_t     sa, sa_nxt;
  stg_b_t     sb, sb_nxt;
  logic       a_load, b_load, accept;

  assign b_load  = !vld_pipe[1] || ready_i;
  assign a_load  = !vld_pipe[0] || b_load;
  assign ready_o = a_load;
  assign accept  = valid_i && ready_o;

  // Stage A: order by magnitude and resolve numeric max/min.
  logic [WIDTH-1:0] b_adj;
  logic [WIDTH-2:0] a_mag, b_mag;
  logic [EW-1:0]    a_exp, b_exp;
  logic             b_bigger, a_num_max;

  always_comb begin
    b_adj            = b_i;
    b_adj[WIDTH-1]   = b_i[WIDTH-1] ^ op_i[2];
    a_mag            = a_i[WIDTH-2:0];
    b_mag            = b_adj[WIDTH-2:0];
    a_exp            = a_i[WIDTH-2 -: EW];
    b_exp            = b_adj[WIDTH-2 -: EW];
    b_bigger         = b_mag > a_mag;
    if (a_i[WIDTH-1] != b_adj[WIDTH-1]) a_num_max = !a_i[WIDTH-1];
    else if (!a_i[WIDTH-1])             a_num_max = !b_bigger;
    else                                a_num_max = a_mag <= b_mag;
    sa_nxt.op        = op_i;
    sa_nxt.a         = a_i;
    sa_nxt.b         = b_adj;
    sa_nxt.swap      = b_bigger;
    sa_nxt.exp_diff  = b_bigger ? (b_exp - a_exp) : (a_exp - b_exp);
    sa_nxt.max_res   = a_num_max ? a_i : b_adj;
    sa_nxt.min_res   = a_num_max ? b_adj : a_i;
  end

  // Stage B: align the smaller significand and form sum/difference.
  logic [WIDTH-1:0] mx, mn;
  logic [SW-1:0]    max_sig, min_sig, aligned;
  logic             big_shift;
`ifdef FP_STD_0_INEXACT_EN
  logic [SW-1:0]    drop_mask;
`endif

  always_comb begin
    mx           = sa.swap ? sa.b : sa.a;
    mn           = sa.swap ? sa.a : sa.b;
    max_sig      = sig_of(mx);
    min_sig      = sig_of(mn);
    big_shift    = |sa.exp_diff[EW-1:4];
    aligned      = big_shift ? '0 : (min_sig >> sa.exp_diff[3:0]);
    sb_nxt.op       = sa.op;
    sb_nxt.add      = {1'b0, max_sig} + {1'b0, aligned};
    sb_nxt.sub      = max_sig - aligned;
    sb_nxt.max_sign = mx[WIDTH-1];
    sb_nxt.min_sign = mn[WIDTH-1];
    sb_nxt.max_res  = sa.max_res;
    sb_nxt.min_res  = sa.min_res;
    sb_nxt.max_exp  = mx[WIDTH-2 -: EW];
`ifdef FP_STD_0_INEXACT_EN
    drop_mask       = big_shift ? '1 : ((SW'(1) << sa.exp_diff[3:0]) - SW'(1));
    sb_nxt.inexact  = |(min_sig & drop_mask);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      sa       <= '0;
      sb       <= '0;
    end else begin
      if (a_load) begin
        vld_pipe[0] <= accept;
        if (accept) sa <= sa_nxt;
      end
      if (b_load) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) sb <= sb_nxt;
      end
    end
  end

  assign valid_o               = vld_pipe[1];
  assign op_o                  = sb.op;
  assign add_result_mantissa_o = sb.add;
  assign sub_result_mantissa_o = sb.sub;
  assign max_sign_o            = sb.max_sign;
  assign min_sign_o            = sb.min_sign;
  assign max_result_o          = sb.max_res;
  assign min_result_o          = sb.min_res;
  assign max_exponent_o        = sb.max_exp;
`ifdef FP_STD_0_INEXACT_EN
  assign inexact_o             = sb.inexact;
`endif

endmodule

// File: tb/tb_fp_std_0.sv
// Bench for fp_std_0: value-level reference model with scoreboard plus directed literal vectors.
module tb_fp_std_0;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, valid_o, ready_i;
  logic [3:0]  op_i, op_o;
  logic [23:0] a_i, b_i, max_result_o, min_result_o;
  logic [16:0] add_o;
  logic [15:0] sub_o;
  logic        max_sign_o, min_sign_o;
  logic [7:0]  max_exponent_o;
  logic        inx_o;

  always #5 clk = ~clk;

  fp_std_0 #(.WIDTH(24)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .op_o(op_o), .add_result_mantissa_o(add_o), .sub_result_mantissa_o(sub_o),
    .max_sign_o(max_sign_o), .min_sign_o(min_sign_o),
    .max_result_o(max_result_o), .min_result_o(min_result_o),
    .max_exponent_o(max_exponent_o)
`ifdef FP_STD_0_INEXACT_EN
    , .inexact_o(inx_o)
`endif
  );
`ifndef FP_STD_0_INEXACT_EN
  assign inx_o = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [16:0] add;
    logic [15:0] sub;
    logic        mxs, mns;
    logic [23:0] mxr, mnr;
    logic [7:0]  mxe;
    logic        inx;
  } bnd_t;

  int   total = 0, bad = 0, drained = 0;
  bnd_t q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: order values by a signed key (-0 just below +0), plain integer alignment.
  function automatic bnd_t model(input logic [23:0] a, input logic [23:0] bi, input logic [3:0] op);
    bnd_t r;
    logic [23:0] b, mx, mn;
    int ma, mb, ka, kb, sx, sn, d, al;
    b = bi;
    if (op[2]) b[23] = ~b[23];
    ma = int'(a[22:0]);
    mb = int'(b[22:0]);
    if (ma >= mb) begin mx = a; mn = b; end else begin mx = b; mn = a; end
    sx = (mx[22:15] == 8'd0) ? 0 : 32768 + int'(mx[14:0]);
    sn = (mn[22:15] == 8'd0) ? 0 : 32768 + int'(mn[14:0]);
    d  = int'(mx[22:15]) - int'(mn[22:15]);
    al = (d >= 16) ? 0 : sn / (1 << d);
    ka = a[23] ? -ma - 1 : ma;
    kb = b[23] ? -mb - 1 : mb;
    r.op  = op;
    r.add = 17'(sx + al);
    r.sub = 16'(sx - al);
    r.mxs = mx[23];
    r.mns = mn[23];
    r.mxr = (ka >= kb) ? a : b;
    r.mnr = (ka >= kb) ? b : a;
    r.mxe = mx[22:15];
`ifdef FP_STD_0_INEXACT_EN
    r.inx = (d >= 16) ? (sn != 0) : ((sn % (1 << d)) != 0);
`else
    r.inx = 1'b0;
`endif
    return r;
  endfunction

  function automatic bnd_t dut_b();
    bnd_t r;
    r.op = op_o; r.add = add_o; r.sub = sub_o; r.mxs = max_sign_o; r.mns = min_sign_o;
    r.mxr = max_result_o; r.mnr = min_result_o; r.mxe = max_exponent_o; r.inx = inx_o;
    return r;
  endfunction

  // Scoreboard: accept/drain decisions taken mid-cycle, when inputs and ready are settled.
  bnd_t saved;
  logic held = 1'b0;
  always @(negedge clk) begin
    bnd_t cur, e;
    cur = dut_b();
    if (rst_i) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) chk("hold_stable", cur, saved);
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("bundle", cur, e);
          drained++;
        end
      end
      if (valid_i && ready_o) q.push_back(model(a_i, b_i, op_i));
      held  = valid_o && !ready_i;
      saved = cur;
    end
  end

  task automatic lit(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                     input logic [16:0] ea, input logic [15:0] es, input logic [7:0] ee,
                     input logic [23:0] emx, input logic [23:0] emn,
                     input logic emxs, input logic emns, input logic einx);
    valid_i = 1; a_i = a; b_i = b; op_i = op;
    @(posedge clk); #1;
    valid_i = 0;
    chk("lat_early", valid_o, 0);
    @(posedge clk); #1;
    chk("lat_valid", valid_o, 1);
    chk("op", op_o, op);
    chk("add", add_o, ea);
    chk("sub", sub_o, es);
    chk("max_exp", max_exponent_o, ee);
    chk("max_res", max_result_o, emx);
    chk("min_res", min_result_o, emn);
    chk("max_sign", max_sign_o, emxs);
    chk("min_sign", min_sign_o, emns);
`ifdef FP_STD_0_INEXACT_EN
    chk("inexact", inx_o, einx);
`else
    if (einx === 1'bx) chk("inexact_x", einx, 0);
`endif
  endtask

  task automatic push(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op);
    logic acc;
    int n;
    valid_i = 1; a_i = a; b_i = b; op_i = op;
    n = 0;
    do begin
      @(negedge clk); acc = ready_o;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", 0, 1);
    valid_i = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || valid_o) && n < 60) begin @(posedge clk); #1; n++; end
    chk("drain_done", q.size(), 0);
  endtask

  logic [23:0] va[8] = '{24'h400000, 24'hC00000, 24'h3F8000, 24'h000000,
                         24'h3F8001, 24'h800000, 24'h450123, 24'hBF8000};
  logic [23:0] vb[8] = '{24'h3F8000, 24'h3F8000, 24'h428765, 24'h800000,
                         24'h378001, 24'h3F8000, 24'hC4FFFF, 24'h3F8000};
  logic [3:0]  vo[8] = '{4'b0000, 4'b0001, 4'b0110, 4'b0010,
                         4'b1011, 4'b0100, 4'b0101, 4'b0000};

  initial begin
    int d0;
    bnd_t m;
    rst_i = 1; valid_i = 0; ready_i = 1; op_i = 0; a_i = 0; b_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_add", add_o, 0);
    chk("rst_maxres", max_result_o, 0);

    m = model(24'h400000, 24'h3F8000, 4'b0000);
    chk("model_pin_add", m.add, 17'h0C000);
    m = model(24'h400000, 24'h378001, 4'b0000);
    chk("model_pin_far", {m.add, m.sub}, {17'h08000, 16'h8000});

    //  a          b          op       add       sub      exp    max        min     mxs mns inx
    lit(24'h400000, 24'h3F8000, 4'b0000, 17'h0C000, 16'h4000, 8'h80, 24'h400000, 24'h3F8000, 0, 0, 0);
    lit(24'h3F8000, 24'h3F8000, 4'b0000, 17'h10000, 16'h0000, 8'h7F, 24'h3F8000, 24'h3F8000, 0, 0, 0);
    lit(24'h400000, 24'h3F8000, 4'b0100, 17'h0C000, 16'h4000, 8'h80, 24'h400000, 24'hBF8000, 0, 1, 0);
    lit(24'h400000, 24'h378001, 4'b0000, 17'h08000, 16'h8000, 8'h80, 24'h400000, 24'h378001, 0, 0, 1);
    lit(24'hC00000, 24'hBF8000, 4'b0001, 17'h0C000, 16'h4000, 8'h80, 24'hBF8000, 24'hC00000, 1, 1, 0);
    lit(24'h000000, 24'h3F8000, 4'b0010, 17'h08000, 16'h8000, 8'h7F, 24'h3F8000, 24'h000000, 0, 0, 0);
    lit(24'h400000, 24'h3F8001, 4'b0000, 17'h0C000, 16'h4000, 8'h80, 24'h400000, 24'h3F8001, 0, 0, 1);
    lit(24'h3F8000, 24'h400000, 4'b1011, 17'h0C000, 16'h4000, 8'h80, 24'h400000, 24'h3F8000, 0, 0, 0);
    lit(24'h800000, 24'h000000, 4'b0000, 17'h00000, 16'h0000, 8'h00, 24'h000000, 24'h800000, 1, 0, 0);
    wait_drain();

    // Back-to-back stream with ready_i high: no bubbles.
    d0 = drained;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1; a_i = va[i]; b_i = vb[i]; op_i = vo[i];
      @(negedge clk);
      chk("stream_ready", ready_o, 1);
      @(posedge clk); #1;
    end
    valid_i = 0;
    repeat (2) @(posedge clk);
    #1 chk("stream_count", drained - d0, 8);

    // Stall 3 cycles with 4 bundles queued.
    d0 = drained;
    ready_i = 0;
    fork
      for (int i = 0; i < 4; i++) push(va[i+2], vb[i+2], vo[i+2]);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_drop", ready_o, 0);
        chk("bp_valid_held", valid_o, 1);
        ready_i = 1;
      end
    join
    wait_drain();
    chk("bp_count", drained - d0, 4);

    // Irregular ready_i pattern against a stream.
    d0 = drained;
    fork
      for (int i = 0; i < 8; i++) push(va[7-i], vb[i], vo[(i+3)%8]);
      begin
        logic [19:0] pat;
        pat = 20'b1011_0010_0111_0001_1010;
        for (int k = 0; k < 20; k++) begin ready_i = pat[k]; @(posedge clk); #1; end
        ready_i = 1;
      end
    join
    wait_drain();
    chk("pattern_count", drained - d0, 8);

    // Reset with two bundles in flight.
    push(24'h400000, 24'h3F8000, 4'b0000);
    push(24'h3F8000, 24'h3F8000, 4'b0000);
    rst_i = 1;
    @(posedge clk); #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 1);
    chk("midrst_data", {add_o, sub_o, max_result_o, min_result_o, max_exponent_o, op_o},
        {17'h0, 16'h0, 24'h0, 24'h0, 8'h0, 4'h0});
    rst_i = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", valid_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
